// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage hazard request/response bundle for hazard_scoreboard
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_SZ  = 5,
  parameter int STALL_CNT_SZ = 16
);
  logic                    i_halt;
  logic                    i_valid_D;
  logic                    i_branch_D;
  logic                    i_reg_write_D;
  logic                    i_mem_read_D;
  logic                    i_muldiv_D;
  logic                    i_use_rs_D;
  logic                    i_use_rt_D;
  logic [REG_ADDR_SZ-1:0]  i_instr_rs_D;
  logic [REG_ADDR_SZ-1:0]  i_instr_rt_D;
  logic [REG_ADDR_SZ-1:0]  i_instr_rd_D;
  logic                    o_stall_pc_HD;
  logic                    o_stall_if_id_HD;
  logic                    o_flush_id_ex_HD;
  logic [STALL_CNT_SZ-1:0] o_stall_count;

  modport master (
    output i_halt, i_valid_D, i_branch_D, i_reg_write_D, i_mem_read_D, i_muldiv_D,
           i_use_rs_D, i_use_rt_D, i_instr_rs_D, i_instr_rt_D, i_instr_rd_D,
    input  o_stall_pc_HD, o_stall_if_id_HD, o_flush_id_ex_HD, o_stall_count
  );

  modport slave (
    input  i_halt, i_valid_D, i_branch_D, i_reg_write_D, i_mem_read_D, i_muldiv_D,
           i_use_rs_D, i_use_rt_D, i_instr_rs_D, i_instr_rt_D, i_instr_rd_D,
    output o_stall_pc_HD, o_stall_if_id_HD, o_flush_id_ex_HD, o_stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register countdown scoreboard driving ID-stage stalls
// Optional multi-cycle MUL/DIV tracking is compiled in with HAZARD_SB_MULDIV_EN.
module hazard_scoreboard #(
  parameter int REG_ADDR_SZ  = 5,
  parameter int LOAD_LAT     = 2,
  parameter int MUL_LAT      = 4,
  parameter int STALL_CNT_SZ = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  hazard_scoreboard_if.slave hz
);
  localparam int NUM_REGS = 2 ** REG_ADDR_SZ;
  localparam int CNT_W    = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // cnt[r]: cycles until register r is forwardable into EX; entry 0 stays zero
  logic [CNT_W-1:0]        cnt [NUM_REGS];
  logic [STALL_CNT_SZ-1:0] stall_count;

  logic             muldiv;
  logic [CNT_W-1:0] lat;
  logic             rs_hit, rt_hit, waw, structural, stall, issue, rd_valid;

`ifdef HAZARD_SB_MULDIV_EN
  logic [CNT_W-1:0] busy_cnt;
  assign muldiv     = hz.i_muldiv_D;
  assign structural = muldiv && (busy_cnt > ONE);
`else
  assign muldiv     = hz.i_muldiv_D & 1'b0;
  assign structural = 1'b0;
`endif

  always_comb begin
    lat = ONE;
    if (muldiv)
      lat = CNT_W'(MUL_LAT);
    else if (hz.i_mem_read_D)
      lat = CNT_W'(LOAD_LAT);
  end

  // branches resolve in ID, so they need the value one cycle earlier than EX consumers
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    if (hz.i_use_rs_D && (hz.i_instr_rs_D != '0))
      rs_hit = hz.i_branch_D ? (cnt[hz.i_instr_rs_D] != '0) : (cnt[hz.i_instr_rs_D] > ONE);
    if (hz.i_use_rt_D && (hz.i_instr_rt_D != '0))
      rt_hit = hz.i_branch_D ? (cnt[hz.i_instr_rt_D] != '0) : (cnt[hz.i_instr_rt_D] > ONE);
  end

  assign rd_valid = hz.i_reg_write_D && (hz.i_instr_rd_D != '0);
  assign waw      = rd_valid && (cnt[hz.i_instr_rd_D] > lat);
  assign stall    = hz.i_valid_D && (rs_hit || rt_hit || waw || structural);
  assign issue    = hz.i_valid_D && !stall && !hz.i_halt;

  assign hz.o_stall_pc_HD    = stall;
  assign hz.o_stall_if_id_HD = stall;
  assign hz.o_flush_id_ex_HD = stall;
  assign hz.o_stall_count    = stall_count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt[r] <= '0;
      stall_count <= '0;
    end else if (!hz.i_halt) begin
      for (int r = 1; r < NUM_REGS; r++)
        if (cnt[r] != '0)
          cnt[r] <= cnt[r] - ONE;
      // a fresh producer overrides the decrement of the older one
      if (issue && rd_valid)
        cnt[hz.i_instr_rd_D] <= lat;
      if (stall && (stall_count != '1))
        stall_count <= stall_count + STALL_CNT_SZ'(1);
    end
  end

`ifdef HAZARD_SB_MULDIV_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      busy_cnt <= '0;
    else if (!hz.i_halt) begin
      if (issue && muldiv)
        busy_cnt <= CNT_W'(MUL_LAT);
      else if (busy_cnt != '0)
        busy_cnt <= busy_cnt - ONE;
    end
  end
`endif
endmodule
